// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared ISA fields, opcodes and memory-stage types
package mem_stage_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_LW  = 5'b01000;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_F000;
    localparam logic [31:0] LD_TIMEOUT_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic [4:0] get_opcode(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// rtl/mem_req_fsm.sv - dmem request sequencer with timeout and load buffer
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic                 we,
    input  logic                 ack,
    input  logic [31:0]          rdata,
    output mem_state_e           state,
    output logic                 req,
    output logic                 req_we,
    output logic [ADDR_BITS-1:0] req_addr,
    output logic [31:0]          req_wdata,
    output logic [31:0]          ldbuf,
    output logic                 err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    mem_state_e    next_state;
    logic          timeout;
    logic [CW-1:0] cnt;

    // State register; reset always lands in IDLE, even mid-access.
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state: ack beats timeout, DONE always returns to IDLE.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: if (start) next_state = ST_BUSY;
            ST_BUSY: begin
                if (ack) begin
                    next_state = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    next_state = ST_DONE;
                    timeout    = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Request registers, wait counter, load buffer and sticky error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            req       <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            ldbuf     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req       <= 1'b1;
                        req_we    <= we;
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        cnt       <= '0;
                    end
                end
                ST_BUSY: begin
                    if (ack) begin
                        ldbuf <= rdata;
                        req   <= 1'b0;
                    end else if (timeout) begin
                        ldbuf <= LD_TIMEOUT_DATA;
                        err   <= 1'b1;
                        req   <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: decode, MMIO routing, dmem stall and M/W mux
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          TIMEOUT   = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          xm_pc,
    input  logic [31:0]          xm_o,
    input  logic [31:0]          xm_b,
    input  logic [31:0]          xm_ir,
    input  logic [31:0]          wb_data,
    input  logic                 wm_bypass,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_BITS-1:0] dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata,
    output logic                 mmio_req,
    output logic                 mmio_we,
    output logic [31:0]          mmio_addr,
    output logic [31:0]          mmio_wdata,
    input  logic [31:0]          mmio_rdata,
    output logic                 stall,
    output logic [31:0]          mw_pc,
    output logic [31:0]          mw_o,
    output logic [31:0]          mw_d,
    output logic [31:0]          mw_ir,
    output logic                 err
);

    logic [4:0]  opcode;
    logic        is_lw;
    logic        is_sw;
    logic        mmio_hit;
    logic        dmem_op;
    logic [31:0] sd;
    logic [31:0] ldbuf;
    mem_state_e  state;

    assign opcode   = get_opcode(xm_ir);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign mmio_hit = (is_lw || is_sw) && (xm_o >= MMIO_BASE);
    assign dmem_op  = (is_lw || is_sw) && !mmio_hit;
    assign sd       = wm_bypass ? wb_data : xm_b;

    mem_req_fsm #(
        .ADDR_BITS (ADDR_BITS),
        .TIMEOUT   (TIMEOUT)
    ) u_fsm (
        .clock     (clock),
        .reset     (reset),
        .start     (dmem_op),
        .addr      (xm_o[ADDR_BITS-1:0]),
        .wdata     (sd),
        .we        (is_sw),
        .ack       (dmem_ack),
        .rdata     (dmem_rdata),
        .state     (state),
        .req       (dmem_req),
        .req_we    (dmem_we),
        .req_addr  (dmem_addr),
        .req_wdata (dmem_wdata),
        .ldbuf     (ldbuf),
        .err       (err)
    );

    assign mmio_addr  = xm_o;
    assign mmio_wdata = sd;
    assign mmio_we    = mmio_req & is_sw;

    // Stall, MMIO strobe and M/W mux from registered state and decode only; dmem_ack never reaches here.
    always_comb begin
        mw_pc    = xm_pc;
        mw_o     = xm_o;
        mw_d     = '0;
        mw_ir    = xm_ir;
        stall    = 1'b0;
        mmio_req = 1'b0;
        if (!reset) begin
            mw_ir = '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    stall = 1'b1;
                    mw_ir = '0;
                end
                ST_DONE: begin
                    mw_d = is_lw ? ldbuf : '0;
                end
                default: begin
                    if (mmio_hit) begin
                        mmio_req = 1'b1;
                        mw_d     = is_lw ? mmio_rdata : '0;
                    end else if (dmem_op) begin
                        stall = 1'b1;
                        mw_ir = '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] xm_pc, xm_o, xm_b, xm_ir, wb_data;
    logic        wm_bypass;
    logic        dmem_req, dmem_we;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mmio_req, mmio_we;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        stall;
    logic [31:0] mw_pc, mw_o, mw_d, mw_ir;
    logic        err;

    int checks = 0;
    int failures = 0;

    mem_stage dut (
        .clock(clock), .reset(reset),
        .xm_pc(xm_pc), .xm_o(xm_o), .xm_b(xm_b), .xm_ir(xm_ir),
        .wb_data(wb_data), .wm_bypass(wm_bypass),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata), .stall(stall),
        .mw_pc(mw_pc), .mw_o(mw_o), .mw_d(mw_d), .mw_ir(mw_ir), .err(err)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] IR_ADD = {5'b00000, 27'h0000123};
    localparam logic [31:0] IR_LW  = {5'b01000, 27'h0000456};
    localparam logic [31:0] IR_SW  = {5'b00111, 27'h0000789};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one dmem op already presented on X/M; ack is driven once req has been seen for noack cycles.
    task automatic run_dmem(input int noack, input bit give_ack, input logic [31:0] rd, output int stalls);
        int busy_seen;
        stalls = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (!stall) break;
            stalls++;
            if (dmem_req) busy_seen++;
            step();
            dmem_ack = 1'b0;
            if (give_ack && dmem_req && busy_seen == noack) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; xm_pc = 32'h100; xm_o = 32'h10; xm_b = 32'h1; xm_ir = IR_LW;
        wb_data = 32'h0; wm_bypass = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h0; mmio_rdata = 32'h0;
        step(); step();
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mw_ir !== 32'h0) begin failures++; $display("FAIL reset_mw_ir got=%h exp=0", mw_ir); end
        checks++; if ({dmem_req, dmem_we, err} !== 3'b000) begin failures++; $display("FAIL reset_req_we_err got=%b exp=000", {dmem_req, dmem_we, err}); end
        checks++; if ({dmem_addr, dmem_wdata} !== 44'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h exp=0", {dmem_addr, dmem_wdata}); end
        xm_o = 32'hF004;
        #1;
        checks++; if (mmio_req !== 1'b0) begin failures++; $display("FAIL reset_mmio_req got=%b exp=0", mmio_req); end
        step();
        reset = 1'b1; dmem_ack = 1'b0; xm_ir = IR_ADD; xm_o = 32'h5;
    endtask

    task automatic test_pass_through();
        xm_ir = IR_ADD; xm_o = 32'h5; xm_pc = 32'h200; xm_b = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (mw_o !== 32'h5 || mw_ir !== IR_ADD || mw_pc !== 32'h200 || mw_d !== 32'h0) begin
                failures++; $display("FAIL pass_mw got=%h/%h/%h/%h exp=5/%h/200/0", mw_o, mw_ir, mw_pc, mw_d, IR_ADD); end
            checks++; if (stall !== 1'b0 || dmem_req !== 1'b0 || mmio_req !== 1'b0) begin
                failures++; $display("FAIL pass_stall_req got=%b%b%b exp=000", stall, dmem_req, mmio_req); end
            step();
        end
    endtask

    task automatic test_dmem_lw();
        int stalls;
        xm_ir = IR_LW; xm_o = 32'h10; xm_pc = 32'h204;
        @(negedge clock);
        checks++; if (mw_ir !== 32'h0) begin failures++; $display("FAIL lw_bubble got=%h exp=0", mw_ir); end
        step();
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 12'h010 || dmem_we !== 1'b0) begin
            failures++; $display("FAIL lw_issue got=%b/%h/%b exp=1/010/0", dmem_req, dmem_addr, dmem_we); end
        // Busy cycles issued so far are picked up by the runner's count from its first sample.
        run_dmem(3, 1'b1, 32'hCAFE0001, stalls);
        checks++; if (stalls !== 4) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=4 (after the first)", stalls); end
        checks++; if (mw_d !== 32'hCAFE0001 || mw_ir !== IR_LW || mw_o !== 32'h10 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL lw_done got=%h/%h/%h/%b exp=cafe0001/%h/10/0", mw_d, mw_ir, mw_o, dmem_req, IR_LW); end
        step();
        xm_ir = IR_ADD; xm_o = 32'h8;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0 || mw_ir !== IR_ADD) begin
            failures++; $display("FAIL lw_back_idle got=%b/%b/%h exp=0/0/%h", stall, dmem_req, mw_ir, IR_ADD); end
        step();
    endtask

    task automatic test_dmem_sw();
        xm_ir = IR_SW; xm_o = 32'h24; xm_b = 32'h9999; wb_data = 32'h1234; wm_bypass = 1'b1;
        @(negedge clock);
        checks++; if (stall !== 1'b1 || mw_ir !== 32'h0) begin failures++; $display("FAIL sw_issue_stall got=%b/%h exp=1/0", stall, mw_ir); end
        step();
        wb_data = 32'h5555;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hAAAA; end
            @(negedge clock);
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 12'h024 || dmem_wdata !== 32'h1234) begin
                failures++; $display("FAIL sw_hold got=%b/%b/%h/%h exp=1/1/024/00001234", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sw_busy_stall got=%b exp=1", stall); end
            step();
        end
        dmem_ack = 1'b0;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || mw_d !== 32'h0 || mw_ir !== IR_SW || dmem_req !== 1'b0) begin
            failures++; $display("FAIL sw_done got=%b/%h/%h/%b exp=0/0/%h/0", stall, mw_d, mw_ir, dmem_req, IR_SW); end
        step();
        xm_ir = IR_ADD; wm_bypass = 1'b0;
        step();
    endtask

    task automatic test_mmio();
        int stalls;
        xm_ir = IR_LW; xm_o = 32'hF004; mmio_rdata = 32'h7;
        #1;
        checks++; if (mmio_req !== 1'b1 || mmio_we !== 1'b0 || mmio_addr !== 32'hF004) begin
            failures++; $display("FAIL mmio_lw_strobe got=%b/%b/%h exp=1/0/f004", mmio_req, mmio_we, mmio_addr); end
        checks++; if (mw_d !== 32'h7 || stall !== 1'b0 || mw_ir !== IR_LW) begin
            failures++; $display("FAIL mmio_lw_data got=%h/%b/%h exp=7/0/%h", mw_d, stall, mw_ir, IR_LW); end
        step();
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mmio_no_dmem got=%b exp=0", dmem_req); end
        xm_ir = IR_SW; xm_o = 32'hF000; xm_b = 32'hAB; wm_bypass = 1'b0;
        #1;
        checks++; if (mmio_req !== 1'b1 || mmio_we !== 1'b1 || mmio_wdata !== 32'hAB || mw_d !== 32'h0 || stall !== 1'b0) begin
            failures++; $display("FAIL mmio_sw_base got=%b/%b/%h/%h/%b exp=1/1/ab/0/0", mmio_req, mmio_we, mmio_wdata, mw_d, stall); end
        step();
        xm_ir = IR_LW; xm_o = 32'hEFFC;
        #1;
        checks++; if (mmio_req !== 1'b0 || stall !== 1'b1) begin
            failures++; $display("FAIL below_base_route got=%b/%b exp=0/1", mmio_req, stall); end
        run_dmem(0, 1'b1, 32'h0BEE, stalls);
        checks++; if (dmem_addr !== 12'hFFC || mw_d !== 32'h0BEE || stalls !== 2) begin
            failures++; $display("FAIL below_base_dmem got=%h/%h/%0d exp=ffc/00000bee/2", dmem_addr, mw_d, stalls); end
        step();
        xm_ir = IR_ADD;
        step();
    endtask

    task automatic test_timeout();
        int stalls;
        xm_ir = IR_LW; xm_o = 32'h30;
        run_dmem(0, 1'b0, 32'h0, stalls);
        checks++; if (stalls !== 16) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=16", stalls); end
        checks++; if (err !== 1'b1 || mw_d !== 32'hDEADBEEF || mw_ir !== IR_LW) begin
            failures++; $display("FAIL to_done got=%b/%h/%h exp=1/deadbeef/%h", err, mw_d, mw_ir, IR_LW); end
        step();
        xm_ir = IR_ADD; dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0 || err !== 1'b1) begin
            failures++; $display("FAIL to_late_ack got=%b/%b/%b exp=0/0/1", stall, dmem_req, err); end
        step();
        dmem_ack = 1'b0;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0 || err !== 1'b1) begin
            failures++; $display("FAIL to_after_ack got=%b/%b/%b exp=0/0/1", stall, dmem_req, err); end
        step();
        xm_ir = IR_LW; xm_o = 32'h40;
        run_dmem(1, 1'b1, 32'h55, stalls);
        checks++; if (stalls !== 3 || mw_d !== 32'h55 || err !== 1'b1) begin
            failures++; $display("FAIL to_next_lw got=%0d/%h/%b exp=3/00000055/1", stalls, mw_d, err); end
        step();
        xm_ir = IR_ADD;
        step();
    endtask

    task automatic test_reset_mid_busy();
        int stalls;
        xm_ir = IR_LW; xm_o = 32'h50;
        step();
        @(negedge clock);
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL rst_busy_pre got=%b/%b exp=1/1", dmem_req, stall); end
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || mw_ir !== 32'h0) begin failures++; $display("FAIL rst_held_comb got=%b/%h exp=0/0", stall, mw_ir); end
        @(negedge clock);
        checks++; if (dmem_req !== 1'b0 || err !== 1'b0 || dmem_addr !== 12'h0) begin
            failures++; $display("FAIL rst_busy_clear got=%b/%b/%h exp=0/0/000", dmem_req, err, dmem_addr); end
        step();
        reset = 1'b1; xm_ir = IR_ADD;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h77;
        @(negedge clock);
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL rst_late_ack got=%b/%b exp=0/0", stall, dmem_req); end
        step();
        dmem_ack = 1'b0;
        xm_ir = IR_LW; xm_o = 32'h60;
        run_dmem(0, 1'b1, 32'h600D, stalls);
        checks++; if (stalls !== 2 || mw_d !== 32'h600D || err !== 1'b0) begin
            failures++; $display("FAIL rst_next_lw got=%0d/%h/%b exp=2/0000600d/0", stalls, mw_d, err); end
        step();
        xm_ir = IR_ADD;
        step();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_dmem_lw();
        test_dmem_sw();
        test_mmio();
        test_timeout();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, between the X/M latch outputs and the M/W latch inputs.
- Decodes lw/sw from the X/M instruction and issues a req/ack handshake to data memory (BRAM/arbiter with variable latency). Stalls the pipeline and bubbles M/W until the access completes.
- Routes addresses at or above MMIO_BASE to a single-cycle memory-mapped I/O port (buttons/display), with no stall.

Parameters:
- ADDR_BITS, 12, width of the dmem word address taken from the low bits of the ALU result.
- MMIO_BASE, 32'h0000F000, addresses >= this (unsigned) go to the MMIO port.
- TIMEOUT, 15, maximum BUSY cycles waiting for dmem_ack before the access is aborted.

Ports:
- clock, input, 1, single clock; all state on rising edge.
- reset, input, 1, synchronous, active-low (reset==0 on a rising edge resets).
- xm_pc / xm_o / xm_b / xm_ir, input, 32 each, X/M latch outputs: pc, ALU result (address), rt data, instruction.
- wb_data, input, 32, writeback value for W->M store-data bypass.
- wm_bypass, input, 1, select wb_data instead of xm_b as store data.
- dmem_req / dmem_we, output, 1, request and write-enable; registered.
- dmem_addr, output, ADDR_BITS, registered word address.
- dmem_wdata, output, 32, registered store data.
- dmem_ack, input, 1, single-cycle completion pulse.
- dmem_rdata, input, 32, valid when dmem_ack==1.
- mmio_req / mmio_we, output, 1, combinational MMIO strobe and write flag.
- mmio_addr / mmio_wdata, output, 32, combinational.
- mmio_rdata, input, 32, combinational same-cycle read data.
- stall, output, 1, freezes PC, F/D, D/X and X/M latches.
- mw_pc / mw_o / mw_d / mw_ir, output, 32 each, to M/W latch inputs.
- err, output, 1, sticky: a dmem access timed out.

Behaviour:
- Opcode is xm_ir[31:27]; sw=5'b00111, lw=5'b01000. Any other opcode is pass-through: mw_* = xm_pc, xm_o, 0, xm_ir; no stall.
- Store data sd = wm_bypass ? wb_data : xm_b.
- MMIO path (lw/sw with xm_o >= MMIO_BASE):
  - mmio_req=1, mmio_we=(sw), mmio_addr=xm_o, mmio_wdata=sd, all in the same cycle.
  - For lw, mw_d=mmio_rdata. No stall, FSM untouched.
- Dmem path uses FSM states IDLE, BUSY, DONE:
  - IDLE with dmem lw/sw present: stall=1 and mw_ir=0 (bubble). At the clock edge, latch dmem_addr=xm_o[ADDR_BITS-1:0], dmem_wdata=sd, dmem_we=(sw), set dmem_req=1 and go to BUSY.
  - BUSY: stall=1, mw_ir=0. dmem_req/addr/we/wdata are held stable until ack.
    - On dmem_ack: capture dmem_rdata into ldbuf, drop dmem_req, go to DONE.
    - If the wait counter reaches TIMEOUT with no ack: ldbuf=32'hDEADBEEF, set err, drop req, go to DONE.
    - If ack and timeout coincide, ack wins.
  - DONE: stall=0. mw_* = xm_pc, xm_o, ldbuf (lw) or 0 (sw), xm_ir. Unconditionally go to IDLE next cycle, so the same op is never reissued.
- Latency: a dmem op with ack N cycles after req rises gives 1 (issue) + N + 1 (DONE) stage cycles. Back-to-back dmem ops each pay the full sequence.
- dmem_ack seen in IDLE or DONE is ignored.
- Wait counter clears on entry to BUSY and saturates.
- Reset (reset==0), including mid-BUSY:
  - State goes to IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, ldbuf=0, err=0, counter=0.
  - While reset is held: stall=0, mw_ir=0, mmio_req=0.
  - A late ack after reset is ignored.
- Combinational outputs must not depend on dmem_ack. Only the registered state changes on ack, so no ack->stall comb path exists.

Decomposition:
- Opcode constants (OP_SW, OP_LW, OP_NOP) and field positions go in the shared ISA include used by decode/bypass logic. MMIO_BASE default is also defined there.
- One sub-module: mem_req_fsm, holding state, wait counter, request registers, ldbuf and err. mem_stage keeps the decode, MMIO routing and output muxing.

Test Plan:
- Pass-through: xm_ir=add (op 00000), xm_o=5 -> mw_o=5, mw_ir=xm_ir, stall=0 every cycle, dmem_req never rises.
- Dmem lw, xm_o=32'h10, ack 3 cycles after req with rdata=32'hCAFE0001 -> dmem_addr=12'h010, stall high 5 cycles, then DONE with mw_d=32'hCAFE0001, state back to IDLE.
- Dmem sw with wm_bypass=1, wb_data=32'h1234, xm_b=32'h9999 -> dmem_wdata=32'h1234, dmem_we=1. req/addr/wdata stable until ack; mw_d=0.
- MMIO lw at xm_o=32'hF004, mmio_rdata=32'h7 -> mmio_req=1 same cycle, mw_d=7, stall=0, dmem_req=0.
- No ack for 15 BUSY cycles -> err=1 (sticky), DONE with mw_d=32'hDEADBEEF. A later ack in IDLE is ignored; a following lw proceeds normally.
- reset=0 asserted mid-BUSY -> next edge dmem_req=0, state IDLE, err=0. Ack one cycle after reset release is ignored.
